// File: rtl/jc2_pkg.sv
// Shared types and defaults for the jc2 Johnson LED shifter control slice.
package jc2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_L = 2'd1,
    RUN_R = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int unsigned DEF_DEB_CYCLES = 16;
  localparam int unsigned DEF_PRESCALE   = 6000000;
  localparam int unsigned DEF_STEP_LIMIT = 0;

endpackage

// File: rtl/jc2_if.sv
// Switch inputs and shifter-control outputs of the jc2 sequencer.
interface jc2_if;
  logic left_n;
  logic right_n;
  logic stop_n;
  logic step;
  logic dir;
  logic run;
  logic done;

  modport master (output left_n, right_n, stop_n, input step, dir, run, done);
  modport slave  (input left_n, right_n, stop_n, output step, dir, run, done);
endinterface

// File: rtl/jc2_debounce.sv
// One push switch: 2-FF synchroniser, counting debouncer and press (1->0) detect.
module jc2_debounce
  import jc2_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic press_c
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_prev_q;
  logic [CW-1:0] cnt_q;

  // Any agreement between synchronised and debounced value restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= pin_n;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_c = deb_prev_q & ~deb_q;

endmodule

// File: rtl/jc2_ctrl.sv
// Run/direction sequencer: debounced switches drive an FSM that issues prescaled step pulses.
module jc2_ctrl
  import jc2_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned PRESCALE   = DEF_PRESCALE,
  parameter int unsigned STEP_LIMIT = DEF_STEP_LIMIT
) (
  input logic  clk,
  input logic  rst,
  jc2_if.slave bus
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned SW = (STEP_LIMIT > 1) ? $clog2(STEP_LIMIT + 1) : 1;

  logic left_c, right_c, stop_c;

  jc2_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .rst(rst), .pin_n(bus.left_n),  .press_c(left_c));
  jc2_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .rst(rst), .pin_n(bus.right_n), .press_c(right_c));
  jc2_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop  (.clk(clk), .rst(rst), .pin_n(bus.stop_n),  .press_c(stop_c));

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          dir_q, dir_d;
  logic          run_q;
  logic          entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= DIR_RIGHT;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      run_q   <= (state_d != IDLE);
    end
  end

  // Press priority stop > right > left; a press matching the current direction is ignored.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    dir_d   = dir_q;
    entry   = 1'b0;

    if (stop_c) begin
      state_d = IDLE;
    end else if (right_c) begin
      if (state_q != RUN_R) begin
        state_d = RUN_R;
        entry   = 1'b1;
      end
    end else if (left_c) begin
      if (state_q != RUN_L) begin
        state_d = RUN_L;
        entry   = 1'b1;
      end
    end

    if (state_d == IDLE || entry) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (pre_q == PW'(PRESCALE - 1)) begin
      pre_d  = '0;
      step_d = 1'b1;
      if (STEP_LIMIT != 0) begin
        cnt_d = cnt_q + SW'(1);
        // The limiting step also ends the run on the same edge.
        if (cnt_d == SW'(STEP_LIMIT)) begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end

    if (state_d == RUN_L) begin
      dir_d = DIR_LEFT;
    end else if (state_d == RUN_R) begin
      dir_d = DIR_RIGHT;
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.run  = run_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_jc2_ctrl.sv
// Directed bench for jc2_ctrl with DEB_CYCLES=4, PRESCALE=8 (unlimited and STEP_LIMIT=3 instances).
module tb_jc2_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned PS  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jc2_if bus0 ();
  jc2_if bus1 ();

  jc2_ctrl #(.DEB_CYCLES(DEB), .PRESCALE(PS), .STEP_LIMIT(0)) u_dut (.clk(clk), .rst(rst), .bus(bus0));
  jc2_ctrl #(.DEB_CYCLES(DEB), .PRESCALE(PS), .STEP_LIMIT(3)) u_lim (.clk(clk), .rst(rst), .bus(bus1));

  int n_tests  = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n active edges and land 1 time unit after the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int bounce [14] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int e_ent;
  int tgt;
  logic seen;

  initial begin
    bus0.left_n = 1'b1; bus0.right_n = 1'b1; bus0.stop_n = 1'b1;
    bus1.left_n = 1'b1; bus1.right_n = 1'b1; bus1.stop_n = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state and quiet idle
    check("rst_run",  bus0.run,  1'b0);
    check("rst_dir",  bus0.dir,  1'b0);
    check("rst_step", bus0.step, 1'b0);
    check("rst_done", bus0.done, 1'b0);
    check("rst_lim_run", bus1.run, 1'b0);
    seen = 1'b0;
    repeat (50) begin
      tick;
      if (bus0.step) seen = 1'b1;
    end
    check("idle_step", seen, 1'b0);
    check("idle_run", bus0.run, 1'b0);

    // Bouncing right switch must not produce a press
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus0.right_n = bounce[i][0];
      tick;
      if (bus0.run) seen = 1'b1;
    end
    repeat (6) begin
      tick;
      if (bus0.run) seen = 1'b1;
    end
    check("bounce_run", seen, 1'b0);
    bus0.right_n = 1'b0;
    tick(6);
    check("r_pre_run", bus0.run, 1'b0);
    tick(1);
    check("r_run", bus0.run, 1'b1);
    check("r_dir", bus0.dir, 1'b0);
    bus0.right_n = 1'b1;
    tick(8);

    // Stop from RUN_R
    bus0.stop_n = 1'b0;
    tick(7);
    check("stop_run", bus0.run, 1'b0);
    check("stop_dir", bus0.dir, 1'b0);
    bus0.stop_n = 1'b1;
    tick(8);

    // Left held: state at e6, steps at e14/e22/e30
    bus0.left_n = 1'b0;
    tick(6);
    check("l_pre_run", bus0.run, 1'b0);
    tick(1);
    check("l_run", bus0.run, 1'b1);
    check("l_dir", bus0.dir, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      tick;
      check($sformatf("l_step%0d", k), bus0.step, (k % 8) == 0);
    end
    bus0.left_n = 1'b1;
    tick(8);

    // Right and left together while running left: right wins, prescaler restarts
    bus0.left_n  = 1'b0;
    bus0.right_n = 1'b0;
    tick(7);
    check("both_run", bus0.run, 1'b1);
    check("both_dir", bus0.dir, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick;
      check($sformatf("both_step%0d", k), bus0.step, k == 8);
    end
    bus0.left_n  = 1'b1;
    bus0.right_n = 1'b1;
    tick(8);

    // Back to RUN_L, then stop press lands on a prescaler wrap edge
    bus0.left_n = 1'b0;
    tick(7);
    check("cl_run", bus0.run, 1'b1);
    check("cl_dir", bus0.dir, 1'b1);
    e_ent = edge_cnt;
    bus0.left_n = 1'b1;
    tgt = e_ent + 24;
    while (edge_cnt < tgt - 8) tick;
    check("pre_stop_step", bus0.step, 1'b1);
    tick;
    bus0.stop_n = 1'b0;
    while (edge_cnt < tgt) tick;
    check("ws_step", bus0.step, 1'b0);
    check("ws_run",  bus0.run,  1'b0);
    check("ws_dir",  bus0.dir,  1'b1);
    seen = 1'b0;
    repeat (10) begin
      tick;
      if (bus0.step) seen = 1'b1;
    end
    check("ws_quiet", seen, 1'b0);
    bus0.stop_n = 1'b1;
    tick(8);

    // Reset asserted on what would be a step edge while running left
    bus0.left_n = 1'b0;
    tick(7);
    check("mr_run", bus0.run, 1'b1);
    e_ent = edge_cnt;
    bus0.left_n = 1'b1;
    while (edge_cnt < e_ent + 15) tick;
    rst = 1'b1;
    tick;
    check("mr_step", bus0.step, 1'b0);
    check("mr_run0", bus0.run,  1'b0);
    check("mr_dir",  bus0.dir,  1'b0);
    check("mr_done", bus0.done, 1'b0);
    rst = 1'b0;
    tick(2);

    // STEP_LIMIT=3: three steps, done with the third, then idle
    bus1.right_n = 1'b0;
    tick(7);
    check("lim_run", bus1.run, 1'b1);
    check("lim_dir", bus1.dir, 1'b0);
    bus1.right_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      check($sformatf("lim_step%0d", k), bus1.step, (k == 8) || (k == 16) || (k == 24));
      check($sformatf("lim_done%0d", k), bus1.done, k == 24);
      check($sformatf("lim_run%0d", k),  bus1.run,  k < 24);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
